// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and write-slave FSM state type.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_RESP
    } wr_state_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats
    function automatic logic wrap_len_ok(input logic [31:0] len);
        return (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module axi4_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned AW_LEN     = 8
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [AW_LEN-1:0]     len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] sum;
    logic [ADDR_WIDTH-1:0] win_mask;

    // WRAP keeps the upper bits of the aligned window and wraps the offset
    always_comb begin
        incr      = ADDR_WIDTH'(1) << size;
        sum       = addr + incr;
        win_mask  = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        next_addr = sum;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~win_mask) | (sum & win_mask);
            default:     next_addr = sum;
        endcase
    end

endmodule

// File: rtl/axi4_wr_slave.sv
// AXI4 write-channel slave: accepts one burst at a time and drives a simple memory write port.
module axi4_wr_slave
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned AW_LEN     = 8
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [AW_LEN-1:0]       awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned CNT_W    = AW_LEN + 1;
    localparam int unsigned MAX_SIZE = $clog2(STRB_W);

    wr_state_t             state, state_next;
    logic                  awready_d, wready_d, bvalid_d;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q, next_addr;
    logic [AW_LEN-1:0]     len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  aw_err_q, err_q;
    logic                  aw_hs_c, w_hs_c, cnt_end_c, end_beat_c, len_err_c, aw_err_c;

    assign aw_hs_c    = awvalid & awready;
    assign w_hs_c     = wvalid & wready;
    assign cnt_end_c  = (beat_cnt == {1'b0, len_q});
    assign end_beat_c = w_hs_c & (wlast | cnt_end_c);
    assign len_err_c  = end_beat_c & (wlast ^ cnt_end_c);
    assign aw_err_c   = (awburst == BURST_RSVD) | (awsize > 3'(MAX_SIZE)) |
                        ((awburst == BURST_WRAP) & ~wrap_len_ok(32'(awlen)));

    axi4_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .AW_LEN     (AW_LEN)
    ) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // State register plus the handshake outputs, which follow the next state
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state   <= ST_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
        end else begin
            state   <= state_next;
            awready <= awready_d;
            wready  <= wready_d;
            bvalid  <= bvalid_d;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_next = state;
        awready_d  = 1'b0;
        wready_d   = 1'b0;
        bvalid_d   = 1'b0;
        case (state)
            ST_IDLE: if (aw_hs_c)           state_next = ST_DATA;
            ST_DATA: if (end_beat_c)        state_next = ST_RESP;
            ST_RESP: if (bvalid && bready)  state_next = ST_IDLE;
            default:                        state_next = ST_IDLE;
        endcase
        awready_d = (state_next == ST_IDLE);
        wready_d  = (state_next == ST_DATA);
        bvalid_d  = (state_next == ST_RESP);
    end

    // Burst context: captured at AW accept, advanced on every beat
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            beat_cnt <= '0;
            aw_err_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (aw_hs_c) begin
            id_q     <= awid;
            addr_q   <= awaddr;
            len_q    <= awlen;
            size_q   <= awsize;
            burst_q  <= awburst;
            beat_cnt <= '0;
            aw_err_q <= aw_err_c;
            err_q    <= aw_err_c;
        end else if (w_hs_c) begin
            addr_q   <= next_addr;
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (len_err_c) err_q <= 1'b1;
        end
    end

    // Memory write port, one cycle behind the accepted beat; silent for bad bursts
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            mem_we <= w_hs_c & ~aw_err_q;
            if (w_hs_c) begin
                mem_addr  <= addr_q;
                mem_wdata <= wdata;
                mem_wstrb <= wstrb;
            end
        end
    end

    // Write response, loaded on the end beat and held while waiting for bready
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            bid   <= '0;
            bresp <= RESP_OKAY;
        end else if (end_beat_c) begin
            bid   <= id_q;
            bresp <= (err_q | len_err_c) ? RESP_SLVERR : RESP_OKAY;
        end
    end

endmodule

// File: tb/tb_axi4_wr_slave.sv
// Directed bench for axi4_wr_slave with hand-computed expectations.
module tb_axi4_wr_slave;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [3:0]  q_strb[$];

    axi4_wr_slave dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bid       (bid),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
    );

    always #5 ACLK = ~ACLK;

    // Record every memory write, sampled mid-cycle
    always @(negedge ACLK) begin
        if (mem_we) begin
            q_addr.push_back(mem_addr);
            q_data.push_back(mem_wdata);
            q_strb.push_back(mem_wstrb);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_q();
        q_addr.delete();
        q_data.delete();
        q_strb.delete();
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic ok;
        int   n;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 20) begin
            ok = awready;
            tick();
            n++;
        end
        awvalid = 1'b0;
        if (!ok) check("aw_timeout", 0, 1);
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        logic ok;
        int   n;
        wdata = data; wstrb = strb; wlast = last;
        wvalid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 20) begin
            ok = wready;
            tick();
            n++;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        if (!ok) check("w_timeout", 0, 1);
    endtask

    // AW, then nbeats beats with wlast on the final one; checks both latencies
    task automatic run_burst(input string tag, input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                             input int nbeats, input logic [3:0] strb, input logic [31:0] dbase);
        clear_q();
        send_aw(id, addr, len, size, burst);
        check({tag, "_wready"}, wready, 1);
        check({tag, "_nostale_b"}, bvalid, 0);
        for (int i = 0; i < nbeats; i++)
            send_w(dbase + 32'(i), strb, i == nbeats - 1);
        check({tag, "_bvalid"}, bvalid, 1);
    endtask

    task automatic do_b(input string tag, input logic [3:0] exp_id, input logic [1:0] exp_resp,
                        input int hold);
        check({tag, "_bid"}, bid, exp_id);
        check({tag, "_bresp"}, bresp, exp_resp);
        bready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            check($sformatf("%s_hold%0d_bvalid", tag, i), bvalid, 1);
            check($sformatf("%s_hold%0d_bid", tag, i), bid, exp_id);
            check($sformatf("%s_hold%0d_bresp", tag, i), bresp, exp_resp);
            check($sformatf("%s_hold%0d_awready", tag, i), awready, 0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check({tag, "_bvalid_drop"}, bvalid, 0);
        check({tag, "_awready_back"}, awready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETN = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) tick();

        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        ARESETN = 1'b1;
        check("rel_awready_pre", awready, 0);
        tick();
        check("rel_awready", awready, 1);

        // INCR 0x100, 4 beats
        run_burst("incr", 4'h5, 32'h100, 8'd3, 3'd2, 2'b01, 4, 4'hF, 32'hA000_0000);
        do_b("incr", 4'h5, 2'b00, 0);
        check("incr_nwr", q_addr.size(), 4);
        for (int i = 0; i < 4; i++) if (i < q_addr.size()) begin
            check($sformatf("incr_addr%0d", i), q_addr[i], 32'h100 + 32'(4 * i));
            check($sformatf("incr_data%0d", i), q_data[i], 32'hA000_0000 + 32'(i));
        end

        // WRAP 0x38, 4 beats of 4 bytes in a 16-byte window
        run_burst("wrap", 4'h2, 32'h38, 8'd3, 3'd2, 2'b10, 4, 4'hF, 32'hB000_0000);
        do_b("wrap", 4'h2, 2'b00, 0);
        check("wrap_nwr", q_addr.size(), 4);
        if (q_addr.size() == 4) begin
            check("wrap_addr0", q_addr[0], 32'h38);
            check("wrap_addr1", q_addr[1], 32'h3C);
            check("wrap_addr2", q_addr[2], 32'h30);
            check("wrap_addr3", q_addr[3], 32'h34);
        end

        // FIXED 0x20, 3 beats, partial strobe passes through
        run_burst("fixed", 4'h7, 32'h20, 8'd2, 3'd2, 2'b00, 3, 4'b0011, 32'hC000_0000);
        do_b("fixed", 4'h7, 2'b00, 0);
        check("fixed_nwr", q_addr.size(), 3);
        for (int i = 0; i < 3; i++) if (i < q_addr.size()) begin
            check($sformatf("fixed_addr%0d", i), q_addr[i], 32'h20);
            check($sformatf("fixed_strb%0d", i), q_strb[i], 4'b0011);
        end

        // Reserved burst type: beats taken, nothing written, SLVERR
        run_burst("rsvd", 4'h9, 32'h40, 8'd1, 3'd2, 2'b11, 2, 4'hF, 32'hD000_0000);
        do_b("rsvd", 4'h9, 2'b10, 0);
        check("rsvd_nwr", q_addr.size(), 0);

        // Oversized beat (8 bytes on a 4-byte bus)
        run_burst("size", 4'h1, 32'h80, 8'd0, 3'd3, 2'b01, 1, 4'hF, 32'hE000_0000);
        do_b("size", 4'h1, 2'b10, 0);
        check("size_nwr", q_addr.size(), 0);

        // Early wlast on beat 1 of 4: written normally, SLVERR, B held under backpressure
        run_burst("early", 4'hC, 32'h40, 8'd3, 3'd2, 2'b01, 2, 4'hF, 32'h1234_0000);
        do_b("early", 4'hC, 2'b10, 5);
        check("early_nwr", q_addr.size(), 2);
        if (q_addr.size() == 2) check("early_addr1", q_addr[1], 32'h44);

        // W beat offered while idle is held off, then accepted after AW
        clear_q();
        wdata = 32'h5555_AAAA; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        tick();
        tick();
        check("holdoff_wready", wready, 0);
        check("holdoff_nwr", q_addr.size(), 0);
        send_aw(4'h3, 32'h90, 8'd0, 3'd2, 2'b01);
        send_w(32'h5555_AAAA, 4'hF, 1'b1);
        check("holdoff_bvalid", bvalid, 1);
        do_b("holdoff", 4'h3, 2'b00, 0);
        check("holdoff_nwr1", q_addr.size(), 1);
        if (q_addr.size() == 1) check("holdoff_data", q_data[0], 32'h5555_AAAA);

        // Reset in the middle of a burst
        clear_q();
        send_aw(4'h6, 32'h300, 8'd3, 3'd2, 2'b01);
        send_w(32'hF000_0000, 4'hF, 1'b0);
        send_w(32'hF000_0001, 4'hF, 1'b0);
        check("midrst_we_before", mem_we, 1);
        ARESETN = 1'b0;
        #1;
        check("midrst_awready", awready, 0);
        check("midrst_wready", wready, 0);
        check("midrst_bvalid", bvalid, 0);
        check("midrst_bid", bid, 0);
        check("midrst_bresp", bresp, 0);
        check("midrst_mem_we", mem_we, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_mem_wdata", mem_wdata, 0);
        check("midrst_mem_wstrb", mem_wstrb, 0);
        tick();
        tick();
        clear_q();
        ARESETN = 1'b1;
        tick();
        check("midrst_awready_back", awready, 1);
        run_burst("after", 4'hA, 32'h200, 8'd0, 3'd2, 2'b01, 1, 4'hF, 32'h7777_0000);
        do_b("after", 4'hA, 2'b00, 0);
        check("after_nwr", q_addr.size(), 1);
        if (q_addr.size() == 1) check("after_addr", q_addr[0], 32'h200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
